mem_bank_port_master: RTL and testbench

MEM_BANK_PORT_MASTER -- requirements
Module: mem_bank_port_master

---
 rtl/mem_bank_pkg.sv | 15 +
 rtl/mem_rsp_fifo2.sv | 59 +++++
 rtl/mem_bank_port_master.sv | 124 ++++++++++++
 tb/tb_mem_bank_port_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared defaults and FSM state encoding for the memory bank port master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bank_pkg;

  localparam int DEF_DATA_W = 80;
  localparam int DEF_ADDR_W = 5;

  // INIT clears the whole bank; RUN serves requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rsp_fifo2.sv
// Two-entry read response FIFO; holds captured bank data until consumed.
// Latency: push visible on data_o/valid_o the cycle after push (no bypass).
// Backpressure: head stays stable until popped; push ignored when full.
module mem_rsp_fifo2
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] data_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    push_ok  = push_i && (count_q != 2'd2);
    pop_ok   = pop_i && (count_q != 2'd0);
    wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_ok ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when counted valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = data_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mem_bank_port_master.sv
// Clears a single-port bank after reset/init_req, then serves read/write requests.
// Latency: read data appears on rsp_rdata one cycle after acceptance; writes produce no response.
// Backpressure: req_ready drops when two responses are pending or init_req is high; rsp held until rsp_ready.
module mem_bank_port_master
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_req,
  output logic                init_done,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] be_mask;
  logic              accept;
  logic              rsp_push;
  logic              rsp_pop;
  logic              fifo_valid;
  logic [1:0]        rsp_count;

  // Expand byte enables to a per-bit write mask.
  for (genvar i = 0; i < DATA_W; i++) begin : g_mask
    assign be_mask[i] = req_be[i/8];
  end

  // Next-state and bank port drive; everything is forced idle while reset is high.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_done  = 1'b0;
    req_ready  = 1'b0;
    accept     = 1'b0;
    rsp_push   = 1'b0;
    mem_en     = 1'b0;
    mem_wmode  = 1'b0;
    mem_addr   = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state_q)
        INIT: begin
          mem_en    = 1'b1;
          mem_wmode = 1'b1;
          mem_addr  = init_cnt_q;
          mem_wmask = '1;
          if (init_cnt_q == CNT_MAX) begin
            state_d    = RUN;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        RUN: begin
          init_done  = 1'b1;
          init_cnt_d = '0;
          req_ready  = !init_req && (rsp_count != 2'd2);
          accept     = req_valid && !init_req && (rsp_count != 2'd2);
          // Address follows the request so zero-latency read data is ready at accept.
          mem_addr   = req_addr;
          if (accept) begin
            mem_en    = 1'b1;
            mem_wmode = req_write;
            mem_wdata = req_wdata;
            mem_wmask = be_mask;
            rsp_push  = !req_write;
          end
          if (init_req) begin
            state_d = INIT;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // FSM state and clear counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign rsp_valid = fifo_valid && !reset;
  assign rsp_pop   = rsp_valid && rsp_ready;

  mem_rsp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rsp_push),
    .push_data_i (mem_rdata),
    .pop_i       (rsp_pop),
    .valid_o     (fifo_valid),
    .data_o      (rsp_rdata),
    .count_o     (rsp_count)
  );

endmodule

// File: tb/tb_mem_bank_port_master.sv
// Directed bench for mem_bank_port_master with a behavioural zero-latency bank.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_bank_port_master;

  localparam int DW = 80;
  localparam int AW = 5;
  localparam logic [DW-1:0] W5  = 80'h1234_5678_9ABC_DEF0_1122;
  localparam logic [DW-1:0] M5  = 80'h0000_0000_0000_0000_0022;
  localparam logic [DW-1:0] M7  = 80'h00FF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic            clk = 1'b0;
  logic            reset;
  logic            init_req;
  logic            init_done;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_wmode;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wmask;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural bank: masked write on the clock edge, combinational read.
  logic [DW-1:0] bank [32];
  always @(posedge clk) begin
    if (mem_en && mem_wmode)
      bank[mem_addr] <= (bank[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end
  assign mem_rdata = bank[mem_addr];

  mem_bank_port_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic            v;
    logic            w;
    logic [AW-1:0]   a;
    logic [DW-1:0]   wd;
    logic [DW/8-1:0] be;
    logic            rr;
    logic            e_rdy;
    logic            e_en;
    logic            e_wm;
    logic [DW-1:0]   e_mask;
    logic            e_rv;
    logic [DW-1:0]   e_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic rr);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    rsp_ready = rr;
  endtask

  // Expects to be called just after a clock edge at the first clear cycle.
  task automatic check_clear(input string tag);
    logic ok;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ok = (mem_en === 1'b1) && (mem_wmode === 1'b1) && (mem_addr === 5'(k)) &&
           (mem_wdata === '0) && (mem_wmask === ONES) && (init_done === 1'b0) &&
           (req_ready === 1'b0);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s_clear_cycle%0d: en=%b wmode=%b addr=%0d wdata=%h wmask=%h done=%b rdy=%b expected en=1 wmode=1 addr=%0d wdata=0 wmask=all-ones done=0 rdy=0",
                 tag, k, mem_en, mem_wmode, mem_addr, mem_wdata, mem_wmask, init_done, req_ready, k);
      end
      step();
    end
    chk({tag, "_init_done"}, DW'(init_done), DW'(1));
  endtask

  function automatic vec_t mk(logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic [DW/8-1:0] be, logic rr, logic e_rdy, logic e_en,
                              logic e_wm, logic [DW-1:0] e_mask, logic e_rv, logic [DW-1:0] e_rd);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.wd = wd; r.be = be; r.rr = rr;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_wm = e_wm; r.e_mask = e_mask;
    r.e_rv = e_rv; r.e_rd = e_rd;
    return r;
  endfunction

  initial begin
    //             v  w  a  wdata  be       rr  rdy en wm mask                        rv rdata
    vecs[0]  = mk(1, 1, 5, W5,    10'h001, 1,  1,  1, 1, 80'hFF,                     0, '0);
    vecs[1]  = mk(1, 0, 5, '0,    10'h000, 1,  1,  1, 0, '0,                         0, '0);
    vecs[2]  = mk(0, 0, 0, '0,    10'h000, 1,  1,  0, 0, '0,                         1, M5);
    vecs[3]  = mk(1, 1, 7, ONES,  10'h3FF, 1,  1,  1, 1, ONES,                       0, '0);
    vecs[4]  = mk(1, 1, 7, '0,    10'h200, 1,  1,  1, 1, 80'hFF00_0000_0000_0000_0000, 0, '0);
    vecs[5]  = mk(1, 0, 7, '0,    10'h000, 1,  1,  1, 0, '0,                         0, '0);
    vecs[6]  = mk(1, 0, 5, '0,    10'h000, 1,  1,  1, 0, '0,                         1, M7);
    vecs[7]  = mk(0, 0, 0, '0,    10'h000, 0,  1,  0, 0, '0,                         1, M5);
    vecs[8]  = mk(0, 0, 0, '0,    10'h000, 0,  1,  0, 0, '0,                         1, M5);
    vecs[9]  = mk(0, 0, 0, '0,    10'h000, 1,  1,  0, 0, '0,                         1, M5);
    vecs[10] = mk(0, 0, 0, '0,    10'h000, 1,  1,  0, 0, '0,                         0, '0);

    reset = 1'b1; init_req = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;

    // Outputs quiet while reset is held.
    step();
    @(negedge clk);
    chk("rst_init_done", DW'(init_done), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_mem_en",    DW'(mem_en),    DW'(0));
    step();
    reset = 1'b0;
    check_clear("boot");

    // Table of single-cycle RUN vectors.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].rr);
      req_wdata = vecs[i].wd;
      req_be    = vecs[i].be;
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), DW'(req_ready), DW'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_mem_en", i),    DW'(mem_en),    DW'(vecs[i].e_en));
      chk($sformatf("vec%0d_mem_wmode", i), DW'(mem_wmode), DW'(vecs[i].e_wm));
      chk($sformatf("vec%0d_mem_wmask", i), mem_wmask,      vecs[i].e_mask);
      chk($sformatf("vec%0d_rsp_valid", i), DW'(rsp_valid), DW'(vecs[i].e_rv));
      if (vecs[i].e_en) chk($sformatf("vec%0d_mem_addr", i), DW'(mem_addr), DW'(vecs[i].a));
      if (vecs[i].e_en && vecs[i].w) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
      if (vecs[i].e_rv) chk($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
      step();
    end
    req_be = '0; req_wdata = '0;

    // Back-to-back reads against a stalled response port.
    drive(1, 0, 5, 0);
    @(negedge clk); chk("b2b_a_ready", DW'(req_ready), DW'(1));
    step();
    drive(1, 0, 7, 0);
    @(negedge clk); chk("b2b_b_ready", DW'(req_ready), DW'(1));
    chk("b2b_b_rdata", rsp_rdata, M5);
    step();
    drive(1, 0, 3, 0);
    @(negedge clk); chk("b2b_c_full_ready", DW'(req_ready), DW'(0));
    chk("b2b_c_rsp_valid", DW'(rsp_valid), DW'(1));
    chk("b2b_c_stable", rsp_rdata, M5);
    step();
    drive(1, 0, 3, 1);
    @(negedge clk); chk("b2b_d_ready", DW'(req_ready), DW'(0));
    chk("b2b_d_rdata", rsp_rdata, M5);
    step();
    @(negedge clk); chk("b2b_e_ready", DW'(req_ready), DW'(1));
    chk("b2b_e_rdata", rsp_rdata, M7);
    step();
    drive(0, 0, 0, 1);
    @(negedge clk); chk("b2b_f_rsp_valid", DW'(rsp_valid), DW'(1));
    chk("b2b_f_rdata", rsp_rdata, '0);
    step();
    @(negedge clk); chk("b2b_g_rsp_valid", DW'(rsp_valid), DW'(0));
    step();

    // init_req with one response pending.
    drive(1, 0, 7, 0);
    step();
    drive(1, 0, 5, 0);
    init_req = 1'b1;
    @(negedge clk); chk("ireq_req_ready", DW'(req_ready), DW'(0));
    chk("ireq_mem_en", DW'(mem_en), DW'(0));
    chk("ireq_rsp_valid", DW'(rsp_valid), DW'(1));
    step();
    init_req = 1'b0;
    drive(0, 0, 0, 1);
    chk("ireq_init_done", DW'(init_done), DW'(0));
    chk("ireq_rsp_valid_init", DW'(rsp_valid), DW'(1));
    chk("ireq_rsp_rdata_init", rsp_rdata, M7);
    check_clear("reinit");
    chk("ireq_drained", DW'(rsp_valid), DW'(0));
    drive(1, 0, 5, 1);
    @(negedge clk); chk("ireq_rd5_ready", DW'(req_ready), DW'(1));
    step();
    drive(1, 0, 7, 1);
    @(negedge clk); chk("ireq_rd5_valid", DW'(rsp_valid), DW'(1));
    chk("ireq_rd5_zero", rsp_rdata, '0);
    step();
    drive(0, 0, 0, 1);
    @(negedge clk); chk("ireq_rd7_valid", DW'(rsp_valid), DW'(1));
    chk("ireq_rd7_zero", rsp_rdata, '0);
    step();

    // Reset in the middle of a clear, with a response pending.
    drive(1, 0, 7, 0);
    step();
    drive(0, 0, 0, 0);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    repeat (10) step();
    chk("midrst_addr10", DW'(mem_addr), DW'(10));
    chk("midrst_rsp_held", DW'(rsp_valid), DW'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", DW'(mem_en), DW'(0));
    chk("midrst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("midrst_req_ready", DW'(req_ready), DW'(0));
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    chk("midrst_fifo_flushed", DW'(rsp_valid), DW'(0));
    check_clear("midrst");
    chk("midrst_no_rsp", DW'(rsp_valid), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
